pc_unit: RTL and testbench



---
 rtl/pc_unit.sv | 168 ++++++++++++++++
 tb/tb_pc_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter for the 16-bit datapath.
//
// Holds the PC and selects the next PC from a sequential step, a conditional
// branch (offset already word-shifted upstream), an absolute jump, or a
// register/return target. A misaligned candidate (bit0 set) freezes the unit
// with a sticky fault that only rst clears.
//
// Optional feature macro: PC_RAS_EN
//   Defined   -> RAS_DEPTH-entry circular return-address stack. link pushes
//                pc_seq, pc_src=11 pops the top, and popping an empty stack
//                raises the fault.
//   Undefined -> no stack, link ignored, pc_src=11 jumps to reg_target.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   pc_write       advance the PC this cycle (0 = hold all state)
//   pc_src         00 seq, 01 cond branch, 10 abs jump, 11 register/return
//   branch_cond    branch taken flag (pc_src=01 only)
//   shifted_offset branch offset, already shifted left by 2
//   jump_target    absolute jump address
//   reg_target     register jump address
//   link           call: push return address (PC_RAS_EN only)
//   pc_out         current PC (registered)
//   pc_seq         pc_out + PC_STEP (combinational)
//   fault          sticky misalignment / underflow fault (registered)
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'h0002,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic [1:0]  pc_src,
  input  logic        branch_cond,
  input  logic [15:0] shifted_offset,
  input  logic [15:0] jump_target,
  input  logic [15:0] reg_target,
  input  logic        link,
  output logic [15:0] pc_out,
  output logic [15:0] pc_seq,
  output logic        fault
);

  logic [15:0] pc_r;
  logic        fault_r;
  logic [15:0] cand_s;
  logic        pop_s;
  logic        bad_s;

  assign pc_out = pc_r;
  assign fault  = fault_r;
  // 16-bit modulo add; carry out is intentionally dropped.
  assign pc_seq = pc_r + PC_STEP;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [15:0]      ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_r;     // next slot to be written
  logic [CNT_W-1:0] ras_count_r;   // valid entries, saturates at RAS_DEPTH
  logic [PTR_W-1:0] top_idx_s;
  logic [PTR_W-1:0] ptr_inc_s;
  logic [15:0]      ras_top_s;
  logic             underflow_s;
  logic             unused_reg_target_s;

  assign unused_reg_target_s = ^reg_target;

  // Circular index arithmetic for the stack pointer.
  always_comb begin
    top_idx_s = ras_ptr_r - PTR_W'(1);
    ptr_inc_s = ras_ptr_r + PTR_W'(1);
    if (ras_ptr_r == PTR_W'(0)) begin
      top_idx_s = PTR_W'(RAS_DEPTH - 1);
    end else begin
      top_idx_s = ras_ptr_r - PTR_W'(1);
    end
    if (ras_ptr_r == PTR_W'(RAS_DEPTH - 1)) begin
      ptr_inc_s = PTR_W'(0);
    end else begin
      ptr_inc_s = ras_ptr_r + PTR_W'(1);
    end
  end

  assign ras_top_s   = ras_mem_r[top_idx_s];
  assign underflow_s = pop_s && (ras_count_r == CNT_W'(0));
`else
  logic unused_link_s;

  assign unused_link_s = link ^ (RAS_DEPTH > 0);
`endif

  // Next-PC candidate selection.
  always_comb begin
    cand_s = pc_seq;
    pop_s  = 1'b0;
    case (pc_src)
      2'b00: cand_s = pc_seq;
      2'b01: begin
        if (branch_cond) begin
          cand_s = pc_seq + shifted_offset;
        end else begin
          cand_s = pc_seq;
        end
      end
      2'b10: cand_s = jump_target;
      2'b11: begin
`ifdef PC_RAS_EN
        cand_s = ras_top_s;
        pop_s  = 1'b1;
`else
        cand_s = reg_target;
`endif
      end
      default: cand_s = pc_seq;
    endcase
  end

  // Any fault condition blocks the PC and stack update.
`ifdef PC_RAS_EN
  assign bad_s = cand_s[0] | underflow_s;
`else
  assign bad_s = cand_s[0];
`endif

  // PC, sticky fault and return-stack state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= RESET_VECTOR;
      fault_r <= 1'b0;
`ifdef PC_RAS_EN
      ras_ptr_r   <= PTR_W'(0);
      ras_count_r <= CNT_W'(0);
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= 16'h0000;
      end
`endif
    end else if (pc_write && !fault_r) begin
      if (bad_s) begin
        fault_r <= 1'b1;
      end else begin
        pc_r <= cand_s;
`ifdef PC_RAS_EN
        // Push uses pc_seq of the current PC, independent of pc_src.
        if (pop_s && link) begin
          ras_mem_r[top_idx_s] <= pc_seq;
        end else if (pop_s) begin
          ras_ptr_r   <= top_idx_s;
          ras_count_r <= ras_count_r - CNT_W'(1);
        end else if (link) begin
          // When full, ras_ptr_r already points at the oldest entry.
          ras_mem_r[ras_ptr_r] <= pc_seq;
          ras_ptr_r            <= ptr_inc_s;
          if (ras_count_r != CNT_W'(RAS_DEPTH)) begin
            ras_count_r <= ras_count_r + CNT_W'(1);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        branch_cond;
  logic [15:0] shifted_offset;
  logic [15:0] jump_target;
  logic [15:0] reg_target;
  logic        link;
  logic [15:0] pc_out;
  logic [15:0] pc_seq;
  logic        fault;

  int n_asserts = 0;
  int n_fail    = 0;

  pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .pc_src         (pc_src),
    .branch_cond    (branch_cond),
    .shifted_offset (shifted_offset),
    .jump_target    (jump_target),
    .reg_target     (reg_target),
    .link           (link),
    .pc_out         (pc_out),
    .pc_seq         (pc_seq),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then settle 1ns past the edge.
  task automatic step(input logic w, input logic [1:0] src, input logic bc,
                      input logic [15:0] off, input logic [15:0] jt,
                      input logic [15:0] rt, input logic lk);
    pc_write       = w;
    pc_src         = src;
    branch_cond    = bc;
    shifted_offset = off;
    jump_target    = jt;
    reg_target     = rt;
    link           = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pc_write = 1'b0; pc_src = 2'b00; branch_cond = 1'b0;
    shifted_offset = 16'h0000; jump_target = 16'h0000;
    reg_target = 16'h0000; link = 1'b0;

    // Reset state
    do_reset();
    chk("reset_pc", pc_out, 16'h0000);
    chk("reset_fault", {15'd0, fault}, 16'h0000);
    chk("reset_seq", pc_seq, 16'h0002);

    // Sequential stepping
    step(1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("seq1", pc_out, 16'h0002);
    step(1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("seq2", pc_out, 16'h0004);
    step(1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("seq3", pc_out, 16'h0006);
    chk("seq3_fault", {15'd0, fault}, 16'h0000);

    // Branches from 0010
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0010, 16'h0000, 1'b0);
    chk("jump_0010", pc_out, 16'h0010);
    step(1'b1, 2'b01, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0);
    chk("br_taken", pc_out, 16'h0032);
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0010, 16'h0000, 1'b0);
    step(1'b1, 2'b01, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0);
    chk("br_not_taken", pc_out, 16'h0012);
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0010, 16'h0000, 1'b0);
    step(1'b1, 2'b01, 1'b1, 16'hFFF0, 16'h0000, 16'h0000, 1'b0);
    chk("br_negative", pc_out, 16'h0002);

`ifndef PC_RAS_EN
    // Register jump; link has no effect without the stack
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0ABC, 1'b1);
    chk("reg_jump", pc_out, 16'h0ABC);
`endif

    // pc_write=0 holds everything
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0300, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'(i), 1'b1, 16'h0040, 16'h1000 + 16'(i * 4), 16'h2000, 1'b1);
      chk("hold_pc", pc_out, 16'h0300);
      chk("hold_fault", {15'd0, fault}, 16'h0000);
    end

    // Wrap-around at top of address space
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'hFFFE, 16'h0000, 1'b0);
    chk("seq_wrap_comb", pc_seq, 16'h0000);
    step(1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("seq_wrap", pc_out, 16'h0000);

    // rst wins over pc_write on the same edge
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0400, 16'h0000, 1'b0);
    rst = 1'b1;
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0500, 16'h0000, 1'b0);
    rst = 1'b0;
    chk("rst_priority", pc_out, 16'h0000);

    // Misaligned jump: sticky fault, PC frozen
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0200, 16'h0000, 1'b0);
    chk("pre_fault_pc", pc_out, 16'h0200);
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h1235, 16'h0000, 1'b0);
    chk("misalign_fault", {15'd0, fault}, 16'h0001);
    chk("misalign_hold", pc_out, 16'h0200);
    step(1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0);
    chk("frozen_pc", pc_out, 16'h0200);
    chk("frozen_fault", {15'd0, fault}, 16'h0001);
    do_reset();
    chk("clear_pc", pc_out, 16'h0000);
    chk("clear_fault", {15'd0, fault}, 16'h0000);

    // Misaligned branch offset also faults
    step(1'b1, 2'b01, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    chk("br_misalign_fault", {15'd0, fault}, 16'h0001);
    chk("br_misalign_hold", pc_out, 16'h0000);
    do_reset();

`ifdef PC_RAS_EN
    // Call/return
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0040, 16'h0000, 1'b0);
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0100, 16'h0000, 1'b1);
    chk("call_pc", pc_out, 16'h0100);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0ABC, 1'b0);
    chk("ret_pc", pc_out, 16'h0042);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0ABC, 1'b0);
    chk("underflow_fault", {15'd0, fault}, 16'h0001);
    chk("underflow_hold", pc_out, 16'h0042);
    do_reset();

    // Five calls into a 4-deep stack, then returns newest first
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0010, 16'h0000, 1'b0);
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0100, 16'h0000, 1'b1); // push 0012
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0200, 16'h0000, 1'b1); // push 0102
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0300, 16'h0000, 1'b1); // push 0202
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0400, 16'h0000, 1'b1); // push 0302
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0500, 16'h0000, 1'b1); // push 0402
    chk("call5_pc", pc_out, 16'h0500);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("ret1", pc_out, 16'h0402);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("ret2", pc_out, 16'h0302);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("ret3", pc_out, 16'h0202);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("ret4", pc_out, 16'h0102);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("ret5_fault", {15'd0, fault}, 16'h0001);
    chk("ret5_hold", pc_out, 16'h0102);
    do_reset();

    // Pop with link replaces the top
    step(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0100, 16'h0000, 1'b1); // push 0002
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1); // to 0002, top=0102
    chk("poplink_pc", pc_out, 16'h0002);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("poplink_ret", pc_out, 16'h0102);
    step(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("poplink_empty", {15'd0, fault}, 16'h0001);
    do_reset();
    chk("ras_reset_pc", pc_out, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
